// File: rtl/darkio_regs.sv
// Memory-mapped IO registers: board-ID/IRQ word, LED/GPIO, timer reload and IRQ request/ack.
// Define DARKIO_TICKCNT_EN to add the TICKS expiry counter at word 4.
module darkio_regs #(
  parameter int BOARD_ID = 0,
  parameter int BOARD_CK = 100000000
) (
  input  logic        XCLK,
  input  logic        XRES,
  input  logic        EN,
  input  logic        RE,
  input  logic        WE,
  input  logic [3:0]  BE,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        RACK,
  output logic        WACK,
  output logic [15:0] LED,
  output logic [15:0] GPIO,
  output logic [7:0]  IRQ
);

  localparam logic [7:0]  ID_BYTE   = 8'(BOARD_ID);
  localparam logic [7:0]  CK_MHZ    = 8'(BOARD_CK / 1000000);
  localparam logic [7:0]  CK_FRAC   = 8'((BOARD_CK / 10000) % 100);
  localparam logic [31:0] TMR_RESET = 32'(BOARD_CK / 1000000 - 1);

  logic [7:0]  ireq;
  logic [7:0]  iack;
  logic [31:0] tmr;
  logic [31:0] cnt;
  logic [2:0]  word;
  logic        wr;
  logic        rd;
  logic        expire;
  logic [31:0] rd_data;
  logic        unused_addr;

  assign word        = ADDR[4:2];
  assign unused_addr = ^{ADDR[31:5], ADDR[1:0]};
  assign wr          = EN & WE;
  assign rd          = EN & RE & ~WE;
  assign expire      = (tmr != 32'd0) && (cnt == 32'd0);
  assign IRQ         = ireq ^ iack;

`ifdef DARKIO_TICKCNT_EN
  logic [31:0] ticks;

  // A clear write wins over a same-cycle expiry.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      ticks <= 32'd0;
    end else if (wr && word == 3'd4 && BE != 4'b0000) begin
      ticks <= 32'd0;
    end else if (expire) begin
      ticks <= ticks + 32'd1;
    end
  end
`endif

  always_comb begin
    rd_data = 32'd0;
    case (word)
      3'd0: rd_data = {IRQ, CK_FRAC, CK_MHZ, ID_BYTE};
      3'd2: rd_data = {GPIO, LED};
      3'd3: rd_data = tmr;
`ifdef DARKIO_TICKCNT_EN
      3'd4: rd_data = ticks;
`endif
      default: rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      RDATA <= 32'd0;
      RACK  <= 1'b0;
      WACK  <= 1'b0;
    end else begin
      RACK <= rd;
      WACK <= wr;
      if (rd) begin
        RDATA <= rd_data;
      end
    end
  end

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      LED  <= 16'd0;
      GPIO <= 16'd0;
      tmr  <= TMR_RESET;
    end else if (wr) begin
      if (word == 3'd2) begin
        for (int b = 0; b < 2; b++) begin
          if (BE[b])     LED[8*b +: 8]  <= WDATA[8*b +: 8];
          if (BE[2 + b]) GPIO[8*b +: 8] <= WDATA[16 + 8*b +: 8];
        end
      end
      if (word == 3'd3) begin
        for (int b = 0; b < 4; b++) begin
          if (BE[b]) tmr[8*b +: 8] <= WDATA[8*b +: 8];
        end
      end
    end
  end

  // Reload writes never touch cnt; a new TMR is picked up at the next wrap.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      cnt <= 32'd0;
    end else if (tmr != 32'd0) begin
      cnt <= (cnt == 32'd0) ? tmr : cnt - 32'd1;
    end
  end

  // Both sides use pre-edge state, so an ack landing on an expiry swallows it.
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      ireq <= 8'd0;
      iack <= 8'd0;
    end else begin
      if (wr && word == 3'd0 && BE[3]) begin
        for (int i = 0; i < 8; i++) begin
          if (WDATA[24 + i]) iack[i] <= ireq[i];
        end
      end
      if (expire && ireq == iack) begin
        ireq[7] <= ~iack[7];
      end
    end
  end

endmodule

// File: tb/tb_darkio_regs.sv
// Self-checking bench for darkio_regs: directed vector table, timer/IRQ corner sequences,
// and randomized traffic against a pending-flag reference model.
`timescale 1ns/1ps
module tb_darkio_regs;

  localparam int BOARD_ID = 0;
  localparam int BOARD_CK = 100000000;
  localparam logic [7:0]  ID_BYTE = 8'(BOARD_ID);
  localparam logic [7:0]  ID_MHZ  = 8'(BOARD_CK / 1000000);
  localparam logic [7:0]  ID_FRAC = 8'((BOARD_CK / 10000) % 100);
`ifdef DARKIO_TICKCNT_EN
  localparam bit TICKS_ON = 1'b1;
`else
  localparam bit TICKS_ON = 1'b0;
`endif
  localparam logic [31:0] TICK_AFTER_RESET = TICKS_ON ? 32'd1 : 32'd0;
  localparam logic [31:0] TICK_AFTER_20    = TICKS_ON ? 32'd10 : 32'd0;

  logic        XCLK;
  logic        XRES;
  logic        EN;
  logic        RE;
  logic        WE;
  logic [3:0]  BE;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        RACK;
  logic        WACK;
  logic [15:0] LED;
  logic [15:0] GPIO;
  logic [7:0]  IRQ;

  darkio_regs #(.BOARD_ID(BOARD_ID), .BOARD_CK(BOARD_CK)) dut (
    .XCLK(XCLK), .XRES(XRES), .EN(EN), .RE(RE), .WE(WE), .BE(BE),
    .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .RACK(RACK), .WACK(WACK),
    .LED(LED), .GPIO(GPIO), .IRQ(IRQ)
  );

  initial XCLK = 1'b0;
  always #5 XCLK = ~XCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: one pending flag stands in for the request/ack pair.
  logic [15:0] m_led, m_gpio;
  logic [31:0] m_tmr, m_cnt, m_rdata, m_ticks;
  logic        m_pend, m_rack, m_wack;

  typedef struct {
    logic        en, re, we;
    logic [3:0]  be;
    logic [2:0]  word;
    logic [31:0] wdata;
    logic        exp_rack, exp_wack;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led, exp_gpio;
    logic [7:0]  exp_irq;
  } vec_t;

  vec_t vecs[15];

  task automatic modelReset();
    m_led = 0; m_gpio = 0; m_rdata = 0; m_rack = 0; m_wack = 0;
    m_tmr = BOARD_CK / 1000000 - 1; m_cnt = 0; m_pend = 0; m_ticks = 0;
  endtask

  task automatic modelStep();
    logic        expire, rd, wr, ack, clr;
    logic [2:0]  w;
    logic [31:0] rv;
    w      = ADDR[4:2];
    rd     = EN && RE && !WE;
    wr     = EN && WE;
    expire = (m_tmr != 0) && (m_cnt == 0);
    case (w)
      3'd0:    rv = {(m_pend ? 8'h80 : 8'h00), ID_FRAC, ID_MHZ, ID_BYTE};
      3'd2:    rv = {m_gpio, m_led};
      3'd3:    rv = m_tmr;
      3'd4:    rv = TICKS_ON ? m_ticks : 32'd0;
      default: rv = 32'd0;
    endcase
    m_rack = rd;
    m_wack = wr;
    if (rd) m_rdata = rv;
    ack = wr && w == 3'd0 && BE[3] && WDATA[31];
    clr = wr && w == 3'd4 && BE != 0;
    if (m_pend) m_pend = !ack;
    else        m_pend = expire;
    if (clr) m_ticks = 0;
    else if (expire) m_ticks = m_ticks + 1;
    if (m_tmr != 0) m_cnt = (m_cnt == 0) ? m_tmr : m_cnt - 1;
    if (wr && w == 3'd2) begin
      if (BE[0]) m_led[7:0]   = WDATA[7:0];
      if (BE[1]) m_led[15:8]  = WDATA[15:8];
      if (BE[2]) m_gpio[7:0]  = WDATA[23:16];
      if (BE[3]) m_gpio[15:8] = WDATA[31:24];
    end
    if (wr && w == 3'd3) begin
      for (int b = 0; b < 4; b++) if (BE[b]) m_tmr[8*b +: 8] = WDATA[8*b +: 8];
    end
  endtask

  task automatic check32(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic re, input logic we, input logic [3:0] be,
                               input logic [2:0] word, input logic [31:0] wdata);
    EN = en; RE = re; WE = we; BE = be; WDATA = wdata;
    ADDR = {1'b1, 26'($urandom), word, 2'($urandom)};
    @(posedge XCLK);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic er, input logic ew, input logic [31:0] ed,
                             input logic [15:0] el, input logic [15:0] eg, input logic [7:0] ei);
    check32(name, "RACK", 32'(RACK), 32'(er));
    check32(name, "WACK", 32'(WACK), 32'(ew));
    check32(name, "RDATA", RDATA, ed);
    check32(name, "LED", 32'(LED), 32'(el));
    check32(name, "GPIO", 32'(GPIO), 32'(eg));
    check32(name, "IRQ", 32'(IRQ), 32'(ei));
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_rack, m_wack, m_rdata, m_led, m_gpio, m_pend ? 8'h80 : 8'h00);
  endtask

  task automatic idle(input string name);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 32'h0);
    checkModel(name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int found, gap;
    vecs[0]  = '{1, 1, 0, 4'h0, 3'd0, 32'h0,        1, 0, 32'h00006400, 16'h0000, 16'h0000, 8'h80};
    vecs[1]  = '{1, 1, 0, 4'h0, 3'd3, 32'h0,        1, 0, 32'h00000063, 16'h0000, 16'h0000, 8'h80};
    vecs[2]  = '{1, 0, 1, 4'h3, 3'd2, 32'hA5A51234, 0, 1, 32'h00000063, 16'h1234, 16'h0000, 8'h80};
    vecs[3]  = '{1, 1, 0, 4'h0, 3'd2, 32'h0,        1, 0, 32'h00001234, 16'h1234, 16'h0000, 8'h80};
    vecs[4]  = '{1, 0, 1, 4'h8, 3'd0, 32'h80000000, 0, 1, 32'h00001234, 16'h1234, 16'h0000, 8'h00};
    vecs[5]  = '{1, 1, 0, 4'h0, 3'd0, 32'h0,        1, 0, 32'h00006400, 16'h1234, 16'h0000, 8'h00};
    vecs[6]  = '{1, 0, 1, 4'hF, 3'd3, 32'h00000000, 0, 1, 32'h00006400, 16'h1234, 16'h0000, 8'h00};
    vecs[7]  = '{1, 1, 1, 4'hF, 3'd1, 32'hFFFFFFFF, 0, 1, 32'h00006400, 16'h1234, 16'h0000, 8'h00};
    vecs[8]  = '{1, 1, 0, 4'h0, 3'd1, 32'h0,        1, 0, 32'h00000000, 16'h1234, 16'h0000, 8'h00};
    vecs[9]  = '{1, 1, 0, 4'h0, 3'd3, 32'h0,        1, 0, 32'h00000000, 16'h1234, 16'h0000, 8'h00};
    vecs[10] = '{1, 1, 0, 4'h0, 3'd4, 32'h0,        1, 0, TICK_AFTER_RESET, 16'h1234, 16'h0000, 8'h00};
    vecs[11] = '{1, 0, 1, 4'hC, 3'd2, 32'hBEEF0000, 0, 1, TICK_AFTER_RESET, 16'h1234, 16'hBEEF, 8'h00};
    vecs[12] = '{1, 1, 0, 4'h0, 3'd2, 32'h0,        1, 0, 32'hBEEF1234, 16'h1234, 16'hBEEF, 8'h00};
    vecs[13] = '{0, 1, 0, 4'h0, 3'd0, 32'h0,        0, 0, 32'hBEEF1234, 16'h1234, 16'hBEEF, 8'h00};
    vecs[14] = '{1, 1, 0, 4'h0, 3'd7, 32'h0,        1, 0, 32'h00000000, 16'h1234, 16'hBEEF, 8'h00};

    XRES = 1'b0; EN = 0; RE = 0; WE = 0; BE = 0; ADDR = 0; WDATA = 0;
    modelReset();
    repeat (3) @(posedge XCLK);
    #1;
    checkOutput("reset", 0, 0, 32'h0, 16'h0, 16'h0, 8'h0);
    @(negedge XCLK);
    XRES = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].en, vecs[i].re, vecs[i].we, vecs[i].be, vecs[i].word, vecs[i].wdata);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_rack, vecs[i].exp_wack, vecs[i].exp_rdata,
                  vecs[i].exp_led, vecs[i].exp_gpio, vecs[i].exp_irq);
    end

    // Timer period, ack, drop-while-pending and ack-on-expiry.
    applyStimulus(1, 0, 1, 4'hF, 3'd3, 32'd4);
    checkModel("tmr_write");
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      idle("wait_rise");
      if (IRQ[7]) found = 1;
    end
    check32("irq_rise", "found", 32'(found), 32'd1);
    applyStimulus(1, 0, 1, 4'h8, 3'd0, 32'h80000000);
    checkModel("ack");
    check32("ack_clear", "IRQ", 32'(IRQ), 32'h0);
    gap = 0; found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      idle("wait_rerise");
      gap++;
      if (IRQ[7]) found = 1;
    end
    check32("period", "idle_cycles", 32'(gap), 32'd4);
    repeat (15) idle("pend_hold");
    check32("pend_hold", "IRQ", 32'(IRQ), 32'h80);
    repeat (4) idle("pre_expiry");
    applyStimulus(1, 0, 1, 4'h8, 3'd0, 32'h80000000);
    checkModel("ack_on_expiry");
    check32("ack_on_expiry", "IRQ", 32'(IRQ), 32'h0);
    repeat (4) idle("stay_clear");
    check32("stay_clear", "IRQ", 32'(IRQ), 32'h0);
    idle("next_expiry");
    check32("next_expiry", "IRQ", 32'(IRQ), 32'h80);

    // Expiry counter with a two-cycle period.
    applyStimulus(1, 0, 1, 4'hF, 3'd3, 32'd1);
    checkModel("tmr1");
    repeat (10) idle("settle");
    applyStimulus(1, 0, 1, 4'hF, 3'd4, 32'h12345678);
    checkModel("ticks_clr");
    repeat (20) idle("ticks_run");
    applyStimulus(1, 1, 0, 4'h0, 3'd4, 32'h0);
    checkModel("ticks_read");
    check32("ticks_20", "RDATA", RDATA, TICK_AFTER_20);
    applyStimulus(1, 0, 1, 4'h1, 3'd4, 32'h0);
    checkModel("ticks_clr2");
    applyStimulus(1, 1, 0, 4'h0, 3'd4, 32'h0);
    check32("ticks_cleared", "RDATA", RDATA, 32'h0);

    // Back-to-back reads.
    applyStimulus(1, 1, 0, 4'h0, 3'd0, 32'h0); checkModel("b2b_w0");
    applyStimulus(1, 1, 0, 4'h0, 3'd2, 32'h0); checkModel("b2b_w2");
    check32("b2b_w2", "RDATA", RDATA, 32'hBEEF1234);
    applyStimulus(1, 1, 0, 4'h0, 3'd3, 32'h0); checkModel("b2b_w3");
    check32("b2b_w3", "RDATA", RDATA, 32'h1);
    applyStimulus(1, 1, 0, 4'h0, 3'd1, 32'h0); checkModel("b2b_w1");
    check32("b2b_w1", "RACK", 32'(RACK), 32'h1);

    for (int k = 0; k < 400; k++) begin
      logic [2:0]  w;
      logic [31:0] d;
      w = 3'($urandom);
      d = $urandom;
      if (w == 3'd3) d = $urandom_range(0, 9);
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 4'($urandom), w, d);
      checkModel("random");
    end

    // Reset asserted while a read is in flight.
    EN = 1; RE = 1; WE = 0; ADDR = 32'h8000000C;
    #2;
    XRES = 1'b0;
    @(posedge XCLK);
    #1;
    modelReset();
    checkOutput("reset_mid_read", 0, 0, 32'h0, 16'h0, 16'h0, 8'h0);
    @(negedge XCLK);
    XRES = 1'b1;
    applyStimulus(1, 1, 0, 4'h0, 3'd3, 32'h0);
    checkModel("post_reset");
    check32("post_reset", "RDATA", RDATA, 32'h63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/darkio_regs.md
Name: darkio_regs

Overview:
- Memory-mapped IO register block on the core data path, directly downstream of the SoC memory map.
- Consumes device_bus transactions whose address has ADDR[31] set.
- Holds the board-ID/IRQ word, the LED/GPIO register, the timer reload register and the timer/IRQ request-acknowledge logic.
- Returns read data with a fixed one-cycle RACK/WACK handshake.

Parameters:
- BOARD_ID, 0, board identifier, returned in byte 0 of word 0.
- BOARD_CK, 100000000, board clock in Hz; sets ID-word clock fields and the timer reset value.

Ports:
- XCLK  in  1  system clock, all logic on rising edge.
- XRES  in  1  reset, asynchronous assert, active-low.
- EN  in  1  bus select for this block.
- RE  in  1  read request, qualified by EN.
- WE  in  1  write request, qualified by EN.
- BE  in  4  byte enables for writes.
- ADDR  in  32  byte address; only ADDR[4:2] decoded.
- WDATA  in  32  write data.
- RDATA  out  32  read data.
- RACK  out  1  read acknowledge.
- WACK  out  1  write acknowledge.
- LED  out  16  LED register.
- GPIO  out  16  GPIO register.
- IRQ  out  8  pending interrupts, IREQ^IACK.

Behaviour:
- Reset (XRES=0, async), cleared to 0: RDATA, RACK, WACK, LED, GPIO, IREQ, IACK, counter CNT.
- Reset value of reload TMR: BOARD_CK/1000000-1 (99 at default).
- Handshake:
  - EN&RE&!WE sampled at edge N → RACK=1 and RDATA valid for cycle N+1 only.
  - EN&WE sampled at edge N → register updated at edge N, WACK=1 for cycle N+1 only.
  - EN&RE&WE → treated as a write; no RACK.
  - Back-to-back requests accepted every cycle, fully pipelined, no stalls.
  - RDATA holds its last value when no read is in progress.
- Register map by ADDR[4:2]:
  - 0: read {IRQ[7:0], (BOARD_CK/10000)%100, BOARD_CK/1000000, BOARD_ID}. Write with BE[3]: for each i with WDATA[24+i]=1, IACK[i]<=IREQ[i]. Other bytes read-only.
  - 1: UART slot, not owned here. Read returns 0; write ignored; both still acked.
  - 2: read {GPIO, LED}. Write: BE[0]/BE[1] update LED bytes, BE[2]/BE[3] update GPIO bytes.
  - 3: TMR, 32-bit; per-byte write via BE.
  - 4..7: read 0, write ignored, acked (see optional feature for 4).
- Timer:
  - TMR==0: counter frozen, no requests.
  - TMR!=0: each cycle CNT <= (CNT==0) ? TMR : CNT-1. Period is TMR+1 cycles.
  - Expiry (TMR!=0 and CNT==0) with IREQ==IACK: IREQ[7] <= ~IACK[7], i.e. IRQ[7] becomes 1.
  - Expiry with a request already pending: dropped, not queued.
  - IREQ[6:0] permanently 0 (reserved for future sources).
- Simultaneous ack write and expiry in one cycle:
  - ack uses the pre-edge IREQ and clears the pending bit;
  - expiry compares pre-edge IREQ/IACK, sees pending, and is dropped.
- Writing TMR mid-count: CNT is not reloaded; the new value takes effect at the next CNT==0.
- Reset mid-transaction: no RACK/WACK is issued for the aborted request.

Optional Feature:
- Macro DARKIO_TICKCNT_EN.
- Defined:
  - Word 4 is a 32-bit TICKS counter, reset 0, +1 on every timer expiry (TMR!=0, CNT==0), whether or not the IRQ was raised.
  - Wraps 0xFFFFFFFF→0.
  - A write with any BE clears it to 0; a same-cycle expiry is lost.
- Undefined: word 4 reads 0, writes ignored, no counter logic synthesised.

Test Plan:
- Release XRES, read word 0 at default params → RACK next cycle only, RDATA=0x00006400; read word 3 → 0x00000063.
- Write word 2 WDATA=0xA5A5_1234, BE=4'b0011 → WACK next cycle; readback 0x0000_1234, LED=0x1234, GPIO=0x0000.
- Write TMR=4, wait → IRQ[7] rises on every 5th cycle boundary of the count. Write word 0 WDATA=0x8000_0000, BE=4'b1000 → IRQ=0. The next expiry re-raises it.
- Leave IRQ[7] pending across 3 expiries → IRQ stays 1, no extra toggles. Ack on the exact expiry cycle → IRQ=0 afterwards and stays 0 until the following expiry.
- Reads on 4 consecutive cycles to words 0,2,3,1 → 4 consecutive RACK pulses with the matching data, word 1 = 0. EN&RE&WE → WACK only. Assert XRES low mid-read → RACK stays 0, all outputs back to reset values.
- DARKIO_TICKCNT_EN set, TMR=1 → word 4 reads 10 after 20 counted cycles. Write word 4 → reads 0. Without the macro, word 4 always reads 0.
